multi_step_accumulator: RTL and testbench
=========================================

# multi_step_accumulator

Parametrised multi-channel successor to the two-level running accumulator. It drives CHANNELS independent step counters, each advancing by 2^STEP_LOG2. A top-level accumulator adds a constant increment plus the registered sum of all channel counts every enabled cycle. Wrap or saturate mode, overflow reporting, a synchronous clear and built-in formal assertions are added. It sits beside the existing counter blocks as a formal-friendly event/stride accumulator.

## Interface
- WIDTH, 32, bit width of every channel counter and of the accumulator
- CHANNELS, 2, number of step counters (1..8)
- STEP_LOG2, 1, channel step is 2^STEP_LOG2 (0..WIDTH-1)
- INC, 1, constant added to the accumulator each enabled cycle (< 2^WIDTH)
- SATURATE, 0, 0 = wrap modulo 2^WIDTH, 1 = clamp at maximum
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- en  in  1  global advance enable
- ch_en  in  CHANNELS  per-channel advance enable, gated by en
- clr  in  1  synchronous clear of all state; not a reset
- acc_out  out  WIDTH  accumulator value, registered
- ch_out  out  CHANNELS*WIDTH  channel i count at bits [i*WIDTH +: WIDTH], registered
- ch_wrap  out  CHANNELS  one-cycle pulse per channel on wrap or saturation hit
- acc_ovf  out  1  sticky accumulator overflow flag

## Operation
- Reset values: acc_out=0, ch_out=0, ch_wrap=0, acc_ovf=0.
- Priority each cycle: RST > clr > en. clr has the same effect as RST.
- en=0: all state holds. ch_wrap=0.
- Channel i advances when en && ch_en[i]: next = cnt + 2^STEP_LOG2, computed in WIDTH+1 bits.
  - Carry out, wrap mode: truncate to WIDTH bits.
  - Carry out, saturate mode: hold at SMAX = 2^WIDTH - 2^STEP_LOG2.
  - In both cases ch_wrap[i]=1 for exactly the cycle after the update. A counter already sitting at SMAX that is enabled again re-pulses.
- Accumulator updates when en: sum = acc + INC + sum of all ch_out values.
  - sum uses the pre-update (registered) ch_out values of every channel, regardless of ch_en.
  - sum width is WIDTH + clog2(CHANNELS+2).
  - sum > 2^WIDTH-1, wrap mode: truncate to WIDTH bits.
  - sum > 2^WIDTH-1, saturate mode: clamp to 2^WIDTH-1.
  - On overflow acc_ovf sets in the same cycle the acc register updates. It stays set until RST or clr.
- Formal assertions, guarded by !RST, all mandatory:
  - each channel count has its low STEP_LOG2 bits equal to 0;
  - acc_ovf never falls without RST/clr;
  - in saturate mode acc_out and each channel count are non-decreasing except on RST/clr;
  - ch_wrap[i] is never high two cycles running unless the channel is at SMAX.

## Timing
- All outputs are registered with 1-cycle latency from en/ch_en/clr/RST to output change.
- Accumulator sees channel contributions one cycle late: acc(n+1) = acc(n) + INC + sum of ch(n).
- Reset asserted mid-operation zeros everything on the next edge. The first advance occurs on the first edge with RST=0, en=1.

## Structure
- Package multi_step_accumulator_pkg holds:
  - mode constants MODE_WRAP=0 and MODE_SAT=1;
  - a clog2 function;
  - a function returning SMAX from (WIDTH, STEP_LOG2).
- Sub-module step_counter (WIDTH, STEP_LOG2, SATURATE) is instantiated CHANNELS times via generate. It owns its count, wrap pulse and alignment assertion.
- The top level holds the adder tree, accumulator register, acc_ovf and the remaining assertions.

## Test plan
- Defaults, en=1, ch_en=11 from reset -> acc_out 1, 6, 15, 28; ch_out 2, 4, 6, 8 on cycles 1-4.
- WIDTH=8, STEP_LOG2=2, wrap, one channel, en=1 -> count 252 at cycle 63, 0 at cycle 64. ch_wrap pulses at cycle 65 only.
- Same configuration with SATURATE=1 -> count holds at 252 from cycle 63. ch_wrap pulses every cycle from 65 while enabled.
- WIDTH=8, SATURATE=1, ch_en=01 -> channel 1 stays 0. acc_out clamps at 255, acc_ovf=1 and stays at 1 afterwards.
- clr=1 and en=1 together at cycle 5 -> all outputs 0 at cycle 6, acc_ovf cleared. Counting resumes at cycle 7 from acc=1.
- en toggled 1,0,1 -> state frozen during the en=0 cycle. RST pulsed mid-count -> all zero on the next edge, with no assertion failure.

Source files
------------

// File: rtl/multi_step_accumulator_pkg.sv
// Shared constants and helpers for the multi-step accumulator and its step counters.
package multi_step_accumulator_pkg;

  // Overflow handling modes for counters and the accumulator
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Ceiling log2, usable in constant expressions (value >= 1)
  function automatic int clog2_f(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Largest step-aligned count: 2^width - 2^step_log2 (modular for width = 64)
  function automatic logic [63:0] smax_f(input int width, input int step_log2);
    return (64'd1 << width) - (64'd1 << step_log2);
  endfunction

endpackage

// File: rtl/step_counter.sv
// One stride counter: advances by 2^STEP_LOG2, wraps or saturates at the top,
// and raises a one-cycle wrap pulse the cycle after the overflowing update.
module step_counter
  import multi_step_accumulator_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STEP_LOG2 = 1,
  parameter int SATURATE  = MODE_WRAP
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             adv,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH:0]   STEP     = {{WIDTH{1'b0}}, 1'b1} << STEP_LOG2;
  localparam logic [WIDTH-1:0] SMAX     = WIDTH'(smax_f(WIDTH, STEP_LOG2));
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((64'd1 << STEP_LOG2) - 64'd1);
  localparam bit               SAT_MODE = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] cnt_reg;
  logic             carry_reg;
  logic             wrap_reg;
  logic [WIDTH:0]   sum_next;
  logic             carry;

  // One extra bit catches the carry out of the top of the counter
  assign sum_next = {1'b0, cnt_reg} + STEP;
  assign carry    = sum_next[WIDTH];

  // Count update; the carry is staged once so the pulse lands one cycle after the count changes
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      wrap_reg  <= carry_reg;
      carry_reg <= adv && carry;
      if (adv) begin
        if (carry && SAT_MODE) cnt_reg <= SMAX;
        else                   cnt_reg <= sum_next[WIDTH-1:0];
      end
    end
  end

  assign count = cnt_reg;
  assign wrap  = wrap_reg;

  // The count only ever moves in whole steps, so its low bits stay clear
  a_aligned: assert property (@(posedge CLK) disable iff (RST)
    (cnt_reg & LOW_MASK) == '0);

endmodule

// File: rtl/multi_step_accumulator.sv
// Multi-channel stride accumulator: CHANNELS step counters feed an adder chain that,
// together with a constant INC, is folded into a wrapping or saturating accumulator.
module multi_step_accumulator
  import multi_step_accumulator_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter int              CHANNELS  = 2,
  parameter int              STEP_LOG2 = 1,
  parameter longint unsigned INC       = 1,
  parameter int              SATURATE  = MODE_WRAP
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic                      clr,
  output logic [WIDTH-1:0]          acc_out,
  output logic [CHANNELS*WIDTH-1:0] ch_out,
  output logic [CHANNELS-1:0]       ch_wrap,
  output logic                      acc_ovf
);

  // Sum width leaves headroom for acc + INC + every channel without loss
  localparam int               SW       = WIDTH + clog2_f(CHANNELS + 2);
  localparam bit               SAT_MODE = (SATURATE != MODE_WRAP);
  localparam logic [WIDTH-1:0] SMAX     = WIDTH'(smax_f(WIDTH, STEP_LOG2));

  logic [WIDTH-1:0] acc_reg;
  logic             acc_ovf_reg;
  logic [WIDTH-1:0] ch_cnt [CHANNELS];
  logic [SW-1:0]    psum   [CHANNELS+1];
  logic [SW-1:0]    sum;
  logic             ovf_now;

  assign psum[0] = SW'(acc_reg) + SW'(INC);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      step_counter #(
        .WIDTH     (WIDTH),
        .STEP_LOG2 (STEP_LOG2),
        .SATURATE  (SATURATE)
      ) u_step_counter (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (clr),
        .adv   (en && ch_en[gi]),
        .count (ch_cnt[gi]),
        .wrap  (ch_wrap[gi])
      );

      // Registered channel counts feed the chain, so contributions land one cycle late
      assign psum[gi+1] = psum[gi] + SW'(ch_cnt[gi]);
      assign ch_out[gi*WIDTH +: WIDTH] = ch_cnt[gi];

      // Back-to-back pulses are only legal while parked at the top
      a_wrap_pulse: assert property (@(posedge CLK) disable iff (RST)
        (ch_wrap[gi] && $past(ch_wrap[gi])) |-> (ch_cnt[gi] == SMAX));

      if (SAT_MODE) begin : g_sat_mono
        a_ch_mono: assert property (@(posedge CLK) disable iff (RST)
          (!$past(RST) && !$past(clr)) |-> (ch_cnt[gi] >= $past(ch_cnt[gi])));
      end
    end
  endgenerate

  assign sum     = psum[CHANNELS];
  assign ovf_now = |sum[SW-1:WIDTH];

  // Accumulator and sticky overflow flag
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      acc_reg     <= '0;
      acc_ovf_reg <= 1'b0;
    end else if (en) begin
      if (ovf_now) begin
        acc_reg     <= SAT_MODE ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        acc_ovf_reg <= 1'b1;
      end else begin
        acc_reg <= sum[WIDTH-1:0];
      end
    end
  end

  assign acc_out = acc_reg;
  assign acc_ovf = acc_ovf_reg;

  // Overflow flag only drops through reset or clear
  a_ovf_sticky: assert property (@(posedge CLK) disable iff (RST)
    ($past(acc_ovf_reg) && !$past(RST) && !$past(clr)) |-> acc_ovf_reg);

  generate
    if (SAT_MODE) begin : g_acc_mono
      a_acc_mono: assert property (@(posedge CLK) disable iff (RST)
        (!$past(RST) && !$past(clr)) |-> (acc_reg >= $past(acc_reg)));
    end
  endgenerate

endmodule

// File: tb/tb_multi_step_accumulator.sv
// Bench for multi_step_accumulator: four configurations, directed scenarios with
// closed-form expectations, plus randomized runs against an arithmetic reference model.
module tb_multi_step_accumulator;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // d: defaults (WIDTH 32, 2 channels, step 2, wrap)
  logic        d_en = 1'b0, d_clr = 1'b0;
  logic [1:0]  d_chen = 2'b00;
  logic [31:0] d_acc;
  logic [63:0] d_ch;
  logic [1:0]  d_wrap;
  logic        d_ovf;
  // w: WIDTH 8, 1 channel, step 4, wrap
  logic        w_en = 1'b0, w_clr = 1'b0;
  logic [0:0]  w_chen = 1'b1;
  logic [7:0]  w_acc, w_ch;
  logic [0:0]  w_wrap;
  logic        w_ovf;
  // s: WIDTH 8, 1 channel, step 4, saturate
  logic        s_en = 1'b0, s_clr = 1'b0;
  logic [0:0]  s_chen = 1'b1;
  logic [7:0]  s_acc, s_ch;
  logic [0:0]  s_wrap;
  logic        s_ovf;
  // a: WIDTH 8, 2 channels, step 2, saturate
  logic        a_en = 1'b0, a_clr = 1'b0;
  logic [1:0]  a_chen = 2'b00;
  logic [7:0]  a_acc;
  logic [15:0] a_ch;
  logic [1:0]  a_wrap;
  logic        a_ovf;

  multi_step_accumulator dut_d (
    .CLK(CLK), .RST(RST), .en(d_en), .ch_en(d_chen), .clr(d_clr),
    .acc_out(d_acc), .ch_out(d_ch), .ch_wrap(d_wrap), .acc_ovf(d_ovf));

  multi_step_accumulator #(.WIDTH(8), .CHANNELS(1), .STEP_LOG2(2), .INC(1), .SATURATE(0)) dut_w (
    .CLK(CLK), .RST(RST), .en(w_en), .ch_en(w_chen), .clr(w_clr),
    .acc_out(w_acc), .ch_out(w_ch), .ch_wrap(w_wrap), .acc_ovf(w_ovf));

  multi_step_accumulator #(.WIDTH(8), .CHANNELS(1), .STEP_LOG2(2), .INC(1), .SATURATE(1)) dut_s (
    .CLK(CLK), .RST(RST), .en(s_en), .ch_en(s_chen), .clr(s_clr),
    .acc_out(s_acc), .ch_out(s_ch), .ch_wrap(s_wrap), .acc_ovf(s_ovf));

  multi_step_accumulator #(.WIDTH(8), .CHANNELS(2), .STEP_LOG2(1), .INC(1), .SATURATE(1)) dut_a (
    .CLK(CLK), .RST(RST), .en(a_en), .ch_en(a_chen), .clr(a_clr),
    .acc_out(a_acc), .ch_out(a_ch), .ch_wrap(a_wrap), .acc_ovf(a_ovf));

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (one configuration at a time)
  longint m_cnt [2];
  int     m_carry [2];
  bit     m_wrap [2];
  longint m_acc;
  bit     m_ovf;
  int     m_cyc;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_acc = 0; m_ovf = 1'b0; m_cyc = 0;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_carry[i] = -10; m_wrap[i] = 1'b0;
    end
  endtask

  // One clock edge of the specified behaviour, in plain integer arithmetic
  task automatic model_edge(input int w, input int sl2, input int sat, input int nch,
                            input bit rst, input bit clr, input bit en, input logic [1:0] chen);
    longint maxv, step, sum, nxt;
    maxv = (longint'(1) << w) - 1;
    step = longint'(1) << sl2;
    m_cyc++;
    if (rst || clr) begin
      m_acc = 0; m_ovf = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = 0; m_carry[i] = -10; m_wrap[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) m_wrap[i] = (m_carry[i] == m_cyc - 1);
      if (en) begin
        sum = m_acc + 1;
        for (int i = 0; i < nch; i++) sum += m_cnt[i];
        if (sum > maxv) begin
          m_ovf = 1'b1;
          m_acc = (sat != 0) ? maxv : sum % (maxv + 1);
        end else begin
          m_acc = sum;
        end
        for (int i = 0; i < nch; i++) begin
          if (chen[i]) begin
            nxt = m_cnt[i] + step;
            if (nxt > maxv) begin
              m_carry[i] = m_cyc;
              m_cnt[i] = (sat != 0) ? (maxv + 1 - step) : (nxt - (maxv + 1));
            end else begin
              m_cnt[i] = nxt;
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    $display("reset: d acc=%0d w acc=%0d s acc=%0d a acc=%0d", d_acc, w_acc, s_acc, a_acc);
    n_vec++; if (d_acc !== 32'd0 || d_ch !== 64'd0) begin n_err++; $display("FAIL reset_d_state acc=%0d ch=%h want 0", d_acc, d_ch); end
    n_vec++; if (d_wrap !== 2'b00 || d_ovf !== 1'b0) begin n_err++; $display("FAIL reset_d_flags wrap=%b ovf=%b want 0", d_wrap, d_ovf); end
    n_vec++; if (w_acc !== 8'd0 || w_ch !== 8'd0 || w_wrap !== 1'b0 || w_ovf !== 1'b0) begin n_err++; $display("FAIL reset_w acc=%0d ch=%0d wrap=%b ovf=%b want 0", w_acc, w_ch, w_wrap, w_ovf); end
    n_vec++; if (s_acc !== 8'd0 || s_ch !== 8'd0 || s_wrap !== 1'b0 || s_ovf !== 1'b0) begin n_err++; $display("FAIL reset_s acc=%0d ch=%0d wrap=%b ovf=%b want 0", s_acc, s_ch, s_wrap, s_ovf); end
    n_vec++; if (a_acc !== 8'd0 || a_ch !== 16'd0 || a_wrap !== 2'b00 || a_ovf !== 1'b0) begin n_err++; $display("FAIL reset_a acc=%0d ch=%h wrap=%b ovf=%b want 0", a_acc, a_ch, a_wrap, a_ovf); end
    RST = 1'b0;
  endtask

  // Defaults from reset, then clear together with enable at cycle 5
  task automatic test_count_clear();
    longint exp_acc, exp_ch;
    d_en = 1'b1; d_chen = 2'b11;
    for (int n = 1; n <= 7; n++) begin
      d_clr = (n == 6);
      tick();
      if (n <= 5)      begin exp_acc = n + 2 * n * (n - 1); exp_ch = 2 * n; end
      else if (n == 6) begin exp_acc = 0; exp_ch = 0; end
      else             begin exp_acc = 1; exp_ch = 2; end
      $display("count_clear cyc %0d: acc=%0d ch0=%0d ch1=%0d", n, d_acc, d_ch[31:0], d_ch[63:32]);
      n_vec++; if (d_acc !== 32'(exp_acc)) begin n_err++; $display("FAIL count_acc cyc %0d got %0d want %0d", n, d_acc, exp_acc); end
      n_vec++; if (d_ch[31:0] !== 32'(exp_ch) || d_ch[63:32] !== 32'(exp_ch)) begin n_err++; $display("FAIL count_ch cyc %0d got %0d/%0d want %0d", n, d_ch[31:0], d_ch[63:32], exp_ch); end
      n_vec++; if (d_ovf !== 1'b0 || d_wrap !== 2'b00) begin n_err++; $display("FAIL count_flags cyc %0d ovf=%b wrap=%b want 0/00", n, d_ovf, d_wrap); end
    end
    d_clr = 1'b0; d_en = 1'b0;
  endtask

  // en 1,0,1 freezes state; RST mid-count zeros everything on the next edge
  task automatic test_en_toggle();
    logic [31:0] exp_acc [5];
    logic [31:0] exp_ch  [5];
    logic        en_seq  [5];
    logic        rst_seq [5];
    exp_acc = '{32'd1, 32'd1, 32'd6, 32'd0, 32'd1};
    exp_ch  = '{32'd2, 32'd2, 32'd4, 32'd0, 32'd2};
    en_seq  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    rst_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    d_clr = 1'b1; tick(); d_clr = 1'b0;
    d_chen = 2'b11;
    for (int k = 0; k < 5; k++) begin
      d_en = en_seq[k]; RST = rst_seq[k];
      tick();
      $display("en_toggle step %0d: en=%b rst=%b acc=%0d ch0=%0d", k, en_seq[k], rst_seq[k], d_acc, d_ch[31:0]);
      n_vec++; if (d_acc !== exp_acc[k]) begin n_err++; $display("FAIL toggle_acc step %0d got %0d want %0d", k, d_acc, exp_acc[k]); end
      n_vec++; if (d_ch[31:0] !== exp_ch[k] || d_ch[63:32] !== exp_ch[k]) begin n_err++; $display("FAIL toggle_ch step %0d got %0d/%0d want %0d", k, d_ch[31:0], d_ch[63:32], exp_ch[k]); end
    end
    RST = 1'b0; d_en = 1'b0;
  endtask

  task automatic test_channel_wrap();
    int exp_cnt;
    w_en = 1'b1; w_chen = 1'b1;
    for (int n = 1; n <= 66; n++) begin
      tick();
      exp_cnt = (4 * n) % 256;
      $display("channel_wrap cyc %0d: ch=%0d wrap=%b", n, w_ch, w_wrap);
      n_vec++; if (w_ch !== 8'(exp_cnt)) begin n_err++; $display("FAIL wrap_count cyc %0d got %0d want %0d", n, w_ch, exp_cnt); end
      n_vec++; if (w_wrap !== 1'(n == 65)) begin n_err++; $display("FAIL wrap_pulse cyc %0d got %b want %b", n, w_wrap, (n == 65)); end
    end
    w_en = 1'b0;
  endtask

  task automatic test_channel_saturate();
    int exp_cnt;
    s_en = 1'b1; s_chen = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      tick();
      exp_cnt = (4 * n > 252) ? 252 : 4 * n;
      $display("channel_sat cyc %0d: ch=%0d wrap=%b", n, s_ch, s_wrap);
      n_vec++; if (s_ch !== 8'(exp_cnt)) begin n_err++; $display("FAIL sat_count cyc %0d got %0d want %0d", n, s_ch, exp_cnt); end
      n_vec++; if (s_wrap !== 1'(n >= 65)) begin n_err++; $display("FAIL sat_pulse cyc %0d got %b want %b", n, s_wrap, (n >= 65)); end
    end
    s_en = 1'b0;
  endtask

  // Only channel 0 runs: acc(n) = n^2 until it clamps at 255 on cycle 16
  task automatic test_acc_saturate();
    int exp_acc;
    a_en = 1'b1; a_chen = 2'b01;
    for (int n = 1; n <= 20; n++) begin
      tick();
      exp_acc = (n * n > 255) ? 255 : n * n;
      $display("acc_sat cyc %0d: acc=%0d ovf=%b ch0=%0d ch1=%0d", n, a_acc, a_ovf, a_ch[7:0], a_ch[15:8]);
      n_vec++; if (a_acc !== 8'(exp_acc)) begin n_err++; $display("FAIL accsat_acc cyc %0d got %0d want %0d", n, a_acc, exp_acc); end
      n_vec++; if (a_ovf !== 1'(n >= 16)) begin n_err++; $display("FAIL accsat_ovf cyc %0d got %b want %b", n, a_ovf, (n >= 16)); end
      n_vec++; if (a_ch[7:0] !== 8'(2 * n) || a_ch[15:8] !== 8'd0) begin n_err++; $display("FAIL accsat_ch cyc %0d got %0d/%0d want %0d/0", n, a_ch[7:0], a_ch[15:8], 2 * n); end
    end
    a_clr = 1'b1; tick(); a_clr = 1'b0;
    $display("acc_sat clear: acc=%0d ovf=%b ch=%h", a_acc, a_ovf, a_ch);
    n_vec++; if (a_acc !== 8'd0 || a_ovf !== 1'b0 || a_ch !== 16'd0) begin n_err++; $display("FAIL accsat_clear acc=%0d ovf=%b ch=%h want 0", a_acc, a_ovf, a_ch); end
    tick();
    $display("acc_sat resume: acc=%0d ovf=%b ch0=%0d", a_acc, a_ovf, a_ch[7:0]);
    n_vec++; if (a_acc !== 8'd1 || a_ovf !== 1'b0 || a_ch[7:0] !== 8'd2) begin n_err++; $display("FAIL accsat_resume acc=%0d ovf=%b ch0=%0d want 1/0/2", a_acc, a_ovf, a_ch[7:0]); end
    a_en = 1'b0;
  endtask

  // which: 0 = d (32-bit wrap), 1 = w (8-bit wrap, 1 ch), 2 = a (8-bit saturate, 2 ch)
  task automatic run_random(input int which, input int ncyc);
    int w, sl2, sat, nch;
    bit en, clr, rst;
    logic [1:0] chen;
    longint g_acc;
    longint g_ch [2];
    logic [1:0] g_wrap;
    logic g_ovf;
    longint maxv;
    case (which)
      0:       begin w = 32; sl2 = 1; sat = 0; nch = 2; end
      1:       begin w = 8;  sl2 = 2; sat = 0; nch = 1; end
      default: begin w = 8;  sl2 = 1; sat = 1; nch = 2; end
    endcase
    maxv = (longint'(1) << w) - 1;
    RST = 1'b1; tick(); RST = 1'b0;
    model_reset();
    for (int c = 0; c < ncyc; c++) begin
      en   = ($urandom_range(0, 3) != 0);
      chen = 2'($urandom_range(0, 3));
      clr  = ($urandom_range(0, 39) == 0);
      rst  = ($urandom_range(0, 59) == 0);
      RST = rst;
      case (which)
        0:       begin d_en = en; d_chen = chen;    d_clr = clr; end
        1:       begin w_en = en; w_chen = chen[0]; w_clr = clr; end
        default: begin a_en = en; a_chen = chen;    a_clr = clr; end
      endcase
      tick();
      model_edge(w, sl2, sat, nch, rst, clr, en, chen);
      case (which)
        0:       begin g_acc = d_acc; g_ch[0] = d_ch[31:0]; g_ch[1] = d_ch[63:32]; g_wrap = d_wrap; g_ovf = d_ovf; end
        1:       begin g_acc = w_acc; g_ch[0] = w_ch; g_ch[1] = 0; g_wrap = {1'b0, w_wrap}; g_ovf = w_ovf; end
        default: begin g_acc = a_acc; g_ch[0] = a_ch[7:0]; g_ch[1] = a_ch[15:8]; g_wrap = a_wrap; g_ovf = a_ovf; end
      endcase
      $display("random[%0d] %0d: rst=%b clr=%b en=%b ch_en=%b acc=%0d ch=%0d/%0d wrap=%b ovf=%b", which, c, rst, clr, en, chen, g_acc, g_ch[0], g_ch[1], g_wrap, g_ovf);
      n_vec++; if (g_acc != (m_acc & maxv)) begin n_err++; $display("FAIL rand%0d_acc cyc %0d got %0d want %0d", which, c, g_acc, m_acc); end
      n_vec++; if (g_ovf !== m_ovf) begin n_err++; $display("FAIL rand%0d_ovf cyc %0d got %b want %b", which, c, g_ovf, m_ovf); end
      for (int i = 0; i < nch; i++) begin
        n_vec++; if (g_ch[i] != m_cnt[i]) begin n_err++; $display("FAIL rand%0d_ch%0d cyc %0d got %0d want %0d", which, i, c, g_ch[i], m_cnt[i]); end
        n_vec++; if (g_wrap[i] !== m_wrap[i]) begin n_err++; $display("FAIL rand%0d_wrap%0d cyc %0d got %b want %b", which, i, c, g_wrap[i], m_wrap[i]); end
      end
    end
    RST = 1'b0;
    d_en = 1'b0; d_clr = 1'b0; w_en = 1'b0; w_clr = 1'b0; a_en = 1'b0; a_clr = 1'b0;
  endtask

  task automatic test_random_default(); run_random(0, 300); endtask
  task automatic test_random_wrap();    run_random(1, 400); endtask
  task automatic test_random_sat();     run_random(2, 400); endtask

  initial begin
    test_reset();
    test_count_clear();
    test_en_toggle();
    test_channel_wrap();
    test_channel_saturate();
    test_acc_saturate();
    test_random_default();
    test_random_wrap();
    test_random_sat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
